emu_time_dec_gen: RTL

Emulation time manager feeding the trace capture stage.
- Accumulates emulated time from per-block timestep requests.
- Produces a decimated sample strobe so the trace logic records only every (thr+1)-th advancing step.
- Outputs emu_time and emu_dec_cmp connect directly to the trace port probes; everything runs on emu_clk.

---
 rtl/emu_time_pkg.sv | 12 +
 rtl/emu_dt_min.sv | 32 +++
 rtl/emu_time_dec_gen.sv | 110 +++++++++++
 3 files changed

// File: rtl/emu_time_pkg.sv
// Shared widths and types for the emulation time path and the trace port that probes it.
package emu_time_pkg;

   localparam int unsigned EMU_TIME_WIDTH = 64;
   localparam int unsigned EMU_DT_WIDTH   = 32;
   localparam int unsigned EMU_DEC_WIDTH  = 32;

   typedef logic [EMU_TIME_WIDTH-1:0] emu_time_t;
   typedef logic [EMU_DT_WIDTH-1:0]   emu_dt_t;
   typedef logic [EMU_DEC_WIDTH-1:0]  emu_dec_t;

endpackage

// File: rtl/emu_dt_min.sv
// Combinational unsigned minimum over N packed W-bit lanes, built as a log-depth compare tree.
module emu_dt_min #(
   parameter int unsigned N = 2,
   parameter int unsigned W = 32
) (
   input  logic [N*W-1:0] in_i,
   output logic [W-1:0]   min_o
);

   localparam int unsigned LEVELS = (N > 1) ? $clog2(N) : 0;
   localparam int unsigned NP     = 1 << LEVELS;

   for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
      logic [W-1:0] v [NP >> l];
      for (genvar i = 0; i < (NP >> l); i++) begin : g_node
         if (l == 0) begin : g_leaf
            if (i < N) begin : g_in
               assign v[i] = in_i[i*W +: W];
            end else begin : g_pad
               // All-ones padding never wins a minimum.
               assign v[i] = '1;
            end
         end else begin : g_min
            assign v[i] = (g_lvl[l-1].v[2*i] < g_lvl[l-1].v[2*i+1]) ?
                          g_lvl[l-1].v[2*i] : g_lvl[l-1].v[2*i+1];
         end
      end
   end

   assign min_o = g_lvl[LEVELS].v[0];

endmodule

// File: rtl/emu_time_dec_gen.sv
// Emulated-time accumulator with saturation and a decimated sample strobe for trace capture.
// Optional stop-time clamp and emu_stopped output are enabled by defining EMU_STOP_TIME_EN.
module emu_time_dec_gen
   import emu_time_pkg::*;
#(
   parameter int unsigned TIME_WIDTH = EMU_TIME_WIDTH,
   parameter int unsigned DT_WIDTH   = EMU_DT_WIDTH,
   parameter int unsigned N_DT       = 2,
   parameter int unsigned DEC_WIDTH  = EMU_DEC_WIDTH
) (
   input  logic                     emu_clk,
   input  logic                     emu_rst_n,
   input  logic                     emu_run,
   input  logic [N_DT*DT_WIDTH-1:0] emu_dt_req,
   input  logic [DEC_WIDTH-1:0]     emu_dec_thr,
`ifdef EMU_STOP_TIME_EN
   input  logic [TIME_WIDTH-1:0]    emu_stop_time,
   output logic                     emu_stopped,
`endif
   output logic [DT_WIDTH-1:0]      emu_dt,
   output logic [TIME_WIDTH-1:0]    emu_time,
   output logic                     emu_dec_cmp,
   output logic                     emu_time_sat
);

   localparam int unsigned CW = (TIME_WIDTH > DT_WIDTH) ? TIME_WIDTH : DT_WIDTH;

   logic [TIME_WIDTH-1:0] time_q, time_d;
   logic [DEC_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  cmp_q, cmp_d;
   logic                  sat_q, sat_d;
   logic [DT_WIDTH-1:0]   lane_min;
   logic                  adv;
   logic [CW:0]           sum_w;
   logic                  ovf;

   emu_dt_min #(
      .N (N_DT),
      .W (DT_WIDTH)
   ) u_dt_min (
      .in_i  (emu_dt_req),
      .min_o (lane_min)
   );

`ifdef EMU_STOP_TIME_EN
   logic [TIME_WIDTH-1:0] remain;
   logic [CW-1:0]         remain_w;
   logic [CW-1:0]         lane_w;

   always_comb begin
      emu_stopped = (time_q >= emu_stop_time);
      remain      = emu_stop_time - time_q;
      remain_w    = CW'(remain);
      lane_w      = CW'(lane_min);
      emu_dt      = lane_min;
      // Clamp so time lands exactly on the stop point and then holds.
      if (emu_stopped) begin
         emu_dt = '0;
      end else if (remain_w < lane_w) begin
         emu_dt = DT_WIDTH'(remain_w);
      end
   end
`else
   assign emu_dt = lane_min;
`endif

   always_comb begin
      adv    = emu_run && (emu_dt != '0);
      sum_w  = (CW+1)'(time_q) + (CW+1)'(emu_dt);
      ovf    = |sum_w[CW:TIME_WIDTH];
      time_d = time_q;
      cnt_d  = cnt_q;
      sat_d  = sat_q;
      cmp_d  = 1'b0;
      if (adv) begin
         if (ovf) begin
            time_d = '1;
            sat_d  = 1'b1;
         end else begin
            time_d = sum_w[TIME_WIDTH-1:0];
         end
         // >= so a threshold lowered below the running count strobes at once.
         if (cnt_q >= emu_dec_thr) begin
            cnt_d = '0;
            cmp_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge emu_clk or negedge emu_rst_n) begin
      if (!emu_rst_n) begin
         time_q <= '0;
         cnt_q  <= '0;
         cmp_q  <= 1'b0;
         sat_q  <= 1'b0;
      end else begin
         time_q <= time_d;
         cnt_q  <= cnt_d;
         cmp_q  <= cmp_d;
         sat_q  <= sat_d;
      end
   end

   assign emu_time     = time_q;
   assign emu_dec_cmp  = cmp_q;
   assign emu_time_sat = sat_q;

endmodule
